// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions: fetch FSM states, reset PC and instruction width.
package instr_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_HALT
    } fetch_state_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory port, IR hand-off to decode, redirect/halt control.
interface instr_fetch_if #(
    parameter int ADDR_W = 10
);
    import instr_fetch_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_rvalid;
    logic [INSTR_W-1:0]  imem_rdata;

    logic [INSTR_W-1:0]  ir;
    logic [31:0]         ir_pc;
    logic                ir_valid;
    logic                ir_ready;

    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                halt;
    logic                halted;
    logic [31:0]         fetch_count;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        input  imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, halted, fetch_count,
        output imem_rvalid, imem_rdata, ir_ready, redirect_valid, redirect_pc, halt
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem read, IR register to decode.
// Latency: req in t, rvalid in t+k, ir_valid in t+k+1; best case 3 cycles/instr.
// Backpressure: IR held in HOLD until ir_ready; no new request issued meanwhile.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_nxt;
    logic [INSTR_W-1:0]  r_ir;
    logic [31:0]         r_ir_pc;
    logic                r_ir_valid;
    logic                w_ir_valid_nxt;
    logic                w_ir_load;
    logic [31:0]         r_fetch_count;
    logic                w_count_inc;
    logic                r_halted;
    logic                w_halted_nxt;
    logic                w_handshake;

    assign w_handshake = r_ir_valid & bus.ir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: halt, then redirect, then the normal per-state transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_valid_nxt = r_ir_valid;
        w_ir_load      = 1'b0;
        w_count_inc    = 1'b0;
        w_halted_nxt   = r_halted;

        if (r_state != ST_HALT) begin
            if (bus.halt) begin
                w_state_nxt    = ST_HALT;
                w_ir_valid_nxt = 1'b0;
                w_halted_nxt   = 1'b1;
            end else if (bus.redirect_valid) begin
                w_pc_nxt       = bus.redirect_pc;
                w_ir_valid_nxt = 1'b0;
                w_count_inc    = w_handshake;
                // An in-flight read must still be drained before the next request.
                if ((r_state == ST_WAIT || r_state == ST_DROP) && !bus.imem_rvalid) begin
                    w_state_nxt = ST_DROP;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end else begin
                case (r_state)
                    ST_FETCH: w_state_nxt = ST_WAIT;
                    ST_WAIT: begin
                        if (bus.imem_rvalid) begin
                            w_ir_load      = 1'b1;
                            w_ir_valid_nxt = 1'b1;
                            w_pc_nxt       = pc_next(r_pc);
                            w_state_nxt    = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_handshake) begin
                            w_ir_valid_nxt = 1'b0;
                            w_count_inc    = 1'b1;
                            w_state_nxt    = ST_FETCH;
                        end
                    end
                    ST_DROP: begin
                        if (bus.imem_rvalid) begin
                            w_state_nxt = ST_FETCH;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_ir_pc       <= '0;
            r_ir_valid    <= 1'b0;
            r_fetch_count <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_halted   <= w_halted_nxt;
            if (w_ir_load) begin
                r_ir    <= bus.imem_rdata;
                r_ir_pc <= r_pc;
            end
            if (w_count_inc) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Request is gated by reset so nothing is issued while the block is held in reset.
    assign bus.imem_req    = rst_n && (r_state == ST_FETCH);
    assign bus.imem_addr   = r_pc[ADDR_W-1:0];
    assign bus.ir          = r_ir;
    assign bus.ir_pc       = r_ir_pc;
    assign bus.ir_valid    = r_ir_valid;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus wrap and mid-read reset sequences.
module tb_instr_fetch;

    localparam int AW = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    instr_fetch_if #(.ADDR_W(AW)) bus ();

    instr_fetch #(.ADDR_W(AW), .RESET_PC(32'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        rdr;
        logic [31:0] rpc;
        logic        hlt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ir;
        logic [31:0] e_irpc;
        logic [31:0] e_cnt;
        logic        e_hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input int a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic add(input logic rv, input logic [31:0] rd, input logic rdy,
                       input logic rdr, input logic [31:0] rpc, input logic hlt,
                       input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                       input logic [31:0] e_ir, input logic [31:0] e_irpc,
                       input logic [31:0] e_cnt, input logic e_hlt);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc; v.hlt = hlt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ir = e_ir;
        v.e_irpc = e_irpc; v.e_cnt = e_cnt; v.e_hlt = e_hlt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rd, input logic rdy,
                         input logic rdr, input logic [31:0] rpc, input logic hlt);
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rd;
        bus.ir_ready       = rdy;
        bus.redirect_valid = rdr;
        bus.redirect_pc    = rpc;
        bus.halt           = hlt;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_ir, input logic [31:0] e_irpc,
                           input logic [31:0] e_cnt, input logic e_hlt);
        chk({tag, ".imem_req"},    {31'd0, bus.imem_req},      {31'd0, e_req});
        chk({tag, ".imem_addr"},   {{(32-AW){1'b0}}, bus.imem_addr}, e_addr);
        chk({tag, ".ir_valid"},    {31'd0, bus.ir_valid},      {31'd0, e_vld});
        chk({tag, ".ir"},          bus.ir,                     e_ir);
        chk({tag, ".ir_pc"},       bus.ir_pc,                  e_irpc);
        chk({tag, ".fetch_count"}, bus.fetch_count,            e_cnt);
        chk({tag, ".halted"},      {31'd0, bus.halted},        {31'd0, e_hlt});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Four back-to-back fetches, k=1, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 1, 0, 0, 0, 1, i,   0, (i == 0) ? 32'd0 : word(i - 1), (i == 0) ? 32'd0 : i - 1, i, 0);
            add(1, word(i), 1, 0, 0, 0, 0, i, 0, (i == 0) ? 32'd0 : word(i - 1), (i == 0) ? 32'd0 : i - 1, i, 0);
            add(0, 0, 1, 0, 0, 0, 0, i + 1, 1, word(i), i, i, 0);
        end
        // Consumer stalls 5 cycles on the fifth instruction.
        add(0, 0, 0, 0, 0, 0, 1, 4, 0, word(3), 3, 4, 0);
        add(1, word(4), 0, 0, 0, 0, 0, 4, 0, word(3), 3, 4, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 5, 1, word(4), 4, 4, 0);
        add(0, 0, 1, 0, 0, 0, 0, 5, 1, word(4), 4, 4, 0);
        add(0, 0, 1, 0, 0, 0, 1, 5, 0, word(4), 4, 5, 0);
        // Redirect to 100 in WAIT; stale response arrives two cycles later.
        add(0, 0, 1, 1, 100, 0, 0, 5, 0, word(4), 4, 5, 0);
        add(0, 0, 1, 0, 0, 0, 0, 100, 0, word(4), 4, 5, 0);
        add(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 100, 0, word(4), 4, 5, 0);
        add(0, 0, 1, 0, 0, 0, 1, 100, 0, word(4), 4, 5, 0);
        add(1, word(100), 1, 0, 0, 0, 0, 100, 0, word(4), 4, 5, 0);
        add(0, 0, 1, 0, 0, 0, 0, 101, 1, word(100), 100, 5, 0);
        add(0, 0, 1, 0, 0, 0, 1, 101, 0, word(100), 100, 6, 0);
        // Redirect coincident with rvalid: data discarded, refetch at 200.
        add(1, 32'hBAD0_0BAD, 1, 1, 200, 0, 0, 101, 0, word(100), 100, 6, 0);
        add(0, 0, 1, 0, 0, 0, 1, 200, 0, word(100), 100, 6, 0);
        add(1, word(200), 1, 0, 0, 0, 0, 200, 0, word(100), 100, 6, 0);
        // Halt in HOLD with ready high: handshake not counted.
        add(0, 0, 1, 0, 0, 1, 0, 201, 1, word(200), 200, 6, 0);
        add(1, 32'h1234_5678, 1, 0, 0, 0, 0, 201, 0, word(200), 200, 6, 1);

        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc, vecs[i].hlt);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                    vecs[i].e_ir, vecs[i].e_irpc, vecs[i].e_cnt, vecs[i].e_hlt);
            @(negedge clk);
        end

        // HALT is absorbing: redirects, responses and ready are all ignored.
        for (int i = 0; i < 20; i++) begin
            drive(i[0], 32'hFFFF_0000, 1'b1, 1'b1, 32'd7, i[1]);
            #1;
            chk($sformatf("halt%0d.imem_req", i), {31'd0, bus.imem_req}, 32'd0);
            chk($sformatf("halt%0d.ir_valid", i), {31'd0, bus.ir_valid}, 32'd0);
            chk($sformatf("halt%0d.halted", i),   {31'd0, bus.halted},   32'd1);
            @(negedge clk);
        end
        chk("halt.fetch_count", bus.fetch_count, 32'd6);
        chk("halt.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd201);

        // Address wrap: redirect to 2^AW-1 straight out of reset.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd1023, 1'b0);
        #1;
        chk("wrap0.imem_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap1.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd1023);
        chk("wrap1.imem_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        drive(1'b1, word(1023), 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap3.ir_pc", bus.ir_pc, 32'd1023);
        chk("wrap3.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap4.imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("wrap4.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd0);
        @(negedge clk);
        drive(1'b1, word(1024), 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap6.ir_valid", {31'd0, bus.ir_valid}, 32'd1);
        chk("wrap6.ir_pc", bus.ir_pc, 32'd1024);
        chk("wrap6.ir", bus.ir, word(1024));
        chk("wrap6.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);

        // In WAIT with a read outstanding: asynchronous reset clears everything at once.
        #1;
        chk("midwait.imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("midwait.fetch_count", bus.fetch_count, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("rstmid", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst.imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("postrst.imem_addr", {{(32-AW){1'b0}}, bus.imem_addr}, 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the multi-cycle processor. Holds the program counter, issues one read at a time to instruction memory, and latches the returned word into the instruction register that feeds `instr_decode`. It accepts PC redirects from branch and jump resolution, and stops permanently on a halt (exit syscall).

## Interface
- `ADDR_W`, 10: instruction memory word-address width.
- `RESET_PC`, 32'd0: PC value loaded on reset, as a word index.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assertion, active-low.
- `imem_req`  out  1  one-cycle read request pulse.
- `imem_addr`  out  ADDR_W  word address of the request, equal to `pc[ADDR_W-1:0]`.
- `imem_rvalid`  in  1  read data valid; arrives at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  instruction register, wired to the decoder.
- `ir_pc`  out  32  word address of the instruction in `ir`.
- `ir_valid`  out  1  `ir` holds an undelivered instruction.
- `ir_ready`  in  1  the consumer accepts `ir` this cycle.
- `redirect_valid`  in  1  load a new PC (branch taken, `j`, `jr`, `jal`).
- `redirect_pc`  in  32  target word address.
- `halt`  in  1  exit syscall; stops fetching.
- `halted`  out  1  the block is in HALT.
- `fetch_count`  out  32  count of instructions delivered.

## Operation
- States: FETCH, WAIT, HOLD, DROP, HALT.
- FETCH: drive `imem_req`=1 and `imem_addr`=`pc`, then go to WAIT.
- WAIT: on `imem_rvalid`, set `ir`<=`imem_rdata`, `ir_pc`<=`pc`, `ir_valid`<=1 and `pc`<=`pc`+1, then go to HOLD.
- HOLD: on `ir_valid & ir_ready`, clear `ir_valid`, increment `fetch_count`, then go to FETCH.
- DROP: wait for the outstanding `imem_rvalid`, discard the data, then go to FETCH.
- HALT: absorbing state. No requests are issued, `ir_valid`=0 and `halted`=1. Only reset leaves it.
- At most one memory read is outstanding. `imem_req` is asserted only in FETCH.
- Event priority per cycle: `halt` > `redirect_valid` > normal transition.
- Halt in any state: go to HALT and clear `ir_valid`.
  - If a read is outstanding (WAIT), the late `imem_rvalid` is ignored.
  - A handshake in the same cycle is not counted.
- Redirect, in any state other than HALT:
  - `pc`<=`redirect_pc` and `ir_valid`<=0. A same-cycle `ir_ready` handshake still counts: the consumer has taken the instruction.
  - From FETCH or HOLD: next state FETCH.
  - From WAIT without `imem_rvalid` that cycle: next state DROP.
  - From WAIT with `imem_rvalid` that cycle: the data is discarded, next state FETCH.
  - From DROP: the PC is updated, the state stays DROP until the response arrives, or goes to FETCH if `imem_rvalid` is high that cycle.
- Width and wrap rules:
  - `pc`+1 is modulo 2^32.
  - `imem_addr` truncates, so fetch wraps from 2^ADDR_W-1 to 0.
  - `fetch_count` wraps modulo 2^32.
- `imem_rvalid` in FETCH, HOLD or HALT is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH.
  - `ir`=0, `ir_pc`=0, `ir_valid`=0, `imem_req`=0, `halted`=0, `fetch_count`=0.
  - `imem_addr` follows `pc`.
- After `rst_n` rises, the first `imem_req` occurs in the first cycle.
- Latency:
  - `imem_req` in cycle t, `imem_rvalid` in cycle t+k (k≥1), `ir_valid` high in cycle t+k+1.
- Throughput: the best case is one instruction per 3 cycles (FETCH, WAIT, HOLD with `ir_ready` already high).
- All outputs are registered except `imem_req` and `imem_addr`, which decode from state and `pc`.
- If `rst_n` is asserted mid-read, the block resets immediately. Memory must not return stale data after reset; this is a system requirement, not checked by the block.
- `ir` is stable while `ir_valid`=1 and no handshake has occurred.

## Structure
- Shared processor package holds:
  - the fetch state enum (FETCH, WAIT, HOLD, DROP, HALT);
  - the `RESET_PC` default;
  - the 32-bit instruction word width constant used by decode.
- No sub-module. The PC register, FSM and counter are small and stay in this module.

## Test plan
- Reset, memory returns words A0..A3 with k=1, `ir_ready` held at 1 → `ir`=A0..A3 with `ir_pc`=0..3, one instruction per 3 cycles, `fetch_count`=4.
- `ir_ready`=0 for 5 cycles while `ir_valid`=1 → `ir` stable, no `imem_req`; `ir_ready` rises → the next `imem_req` follows one cycle later, at `addr`=`pc`.
- `redirect_valid` with `redirect_pc`=100 while in WAIT, memory answers 2 cycles later → that word is dropped, the next `imem_req` has `addr`=100, and `ir_pc`=100.
- `redirect_valid` in the same cycle as `imem_rvalid` → the data is discarded, `ir_valid` stays 0, and the next fetch is at `redirect_pc`.
- `halt` in HOLD with a simultaneous `ir_ready` → `halted`=1, `ir_valid`=0, `fetch_count` unchanged, and no further `imem_req` for 20 cycles.
- `pc`=2^ADDR_W-1 → the next fetch has `imem_addr`=0 and `ir_pc`=2^ADDR_W. Separately, `rst_n` pulsed low mid-WAIT → all outputs return to reset values immediately.
